// File: rtl/regfile_onehot_wr_pkg.sv
// Shared constants and types for the one-hot-write register file.
package regfile_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ZERO_REG   = 0;
    localparam int unsigned COUNT_W    = 16;

    // Classification of a write-select vector by its population count.
    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_LEGAL   = 2'd1,
        WR_ILLEGAL = 2'd2
    } wr_kind_e;

    // Saturating increment for the accepted-write counter.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_onehot_wr_if.sv
// Writeback/operand-fetch bus of the register file.
interface regfile_onehot_wr_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic [NUM_REGS-1:0] wr_sel;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   rd_addr_a;
    logic [ADDR_W-1:0]   rd_addr_b;
    logic [DATA_W-1:0]   rd_data_a;
    logic [DATA_W-1:0]   rd_data_b;
    logic                wr_err;
    logic [COUNT_W-1:0]  wr_count;

    modport master (
        output wr_sel, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wr_err, wr_count
    );

    modport slave (
        input  wr_sel, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wr_err, wr_count
    );

endinterface

// File: rtl/regfile_onehot_wr_reg32_en.sv
// One register word: load-enable flip-flops with asynchronous active-low clear.
module reg32_en #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Load d when enabled; clear immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_onehot_wr.sv
// 32 x DATA_W register file with one-hot write select, two async read ports,
// multi-hot detection and a saturating accepted-write counter.
module regfile_onehot_wr
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter bit          BYPASS = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    regfile_onehot_wr_if.slave bus
);

    wr_kind_e            wr_kind;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                err_q;
    logic [COUNT_W-1:0]  count_q;

    // Classify the incoming select by popcount.
    always_comb begin
        wr_kind = WR_IDLE;
        case ($countones(bus.wr_sel))
            0:       wr_kind = WR_IDLE;
            1:       wr_kind = WR_LEGAL;
            default: wr_kind = WR_ILLEGAL;
        endcase
    end

    // Register 0 is hardwired; a legal select of it only bumps the counter.
    assign regs[ZERO_REG] = '0;

    for (genvar k = 1; k < NUM_REGS; k++) begin : g_reg
        reg32_en #(
            .DATA_W(DATA_W)
        ) u_reg (
            .clk  (clk),
            .rst_n(rst_n),
            .en   ((wr_kind == WR_LEGAL) && bus.wr_sel[k]),
            .d    (bus.wr_data),
            .q    (regs[k])
        );
    end

    // Sticky multi-hot flag and saturating count of accepted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            if (wr_kind == WR_ILLEGAL) begin
                err_q <= 1'b1;
            end
            if (wr_kind == WR_LEGAL) begin
                count_q <= sat_inc(count_q);
            end
        end
    end

    // Read port A: address 0 is zero, optional same-cycle bypass of a legal write.
    always_comb begin
        bus.rd_data_a = regs[bus.rd_addr_a];
        if (bus.rd_addr_a == ADDR_W'(ZERO_REG)) begin
            bus.rd_data_a = '0;
        end else if (BYPASS && (wr_kind == WR_LEGAL) && bus.wr_sel[bus.rd_addr_a]) begin
            bus.rd_data_a = bus.wr_data;
        end
    end

    // Read port B: same behaviour as port A.
    always_comb begin
        bus.rd_data_b = regs[bus.rd_addr_b];
        if (bus.rd_addr_b == ADDR_W'(ZERO_REG)) begin
            bus.rd_data_b = '0;
        end else if (BYPASS && (wr_kind == WR_LEGAL) && bus.wr_sel[bus.rd_addr_b]) begin
            bus.rd_data_b = bus.wr_data;
        end
    end

    assign bus.wr_err   = err_q;
    assign bus.wr_count = count_q;

endmodule

// File: doc/regfile_onehot_wr.md
Name: regfile_onehot_wr

Overview:
- 32-entry x 32-bit processor register file that consumes the one-hot write-select vector produced by the 5-to-32 write decoder.
- Sits between writeback (data, decoded select) and the operand-fetch stage: two asynchronous read ports, one synchronous write port.
- Register 0 reads as zero.
- Malformed one-hot selects are flagged and suppressed.

Parameters:
- DATA_W, 32, register width in bits.
- BYPASS, 1, 1 = a read of the register being written this cycle returns wr_data; 0 = returns the old stored value.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_sel  in  32  one-hot write select from the decoder; all-zero = no write.
- wr_data  in  DATA_W  write data.
- rd_addr_a  in  5  read port A address.
- rd_addr_b  in  5  read port B address.
- rd_data_a  out  DATA_W  read port A data.
- rd_data_b  out  DATA_W  read port B data.
- wr_err  out  1  sticky flag: an illegal multi-hot wr_sel was seen.
- wr_count  out  16  count of accepted writes; saturates at 16'hFFFF.

Behaviour:
- Reset: rst_n low asynchronously clears all 32 registers, wr_err and wr_count to 0. With all registers 0, rd_data_a and rd_data_b read 0 during reset. Reset may assert mid-write; no partial update survives.
- Write acceptance:
  - Evaluated on each clk rising edge while rst_n is high.
  - popcount(wr_sel)==0: idle, no state change.
  - popcount(wr_sel)==1, bit k: register k <= wr_data; wr_count += 1 (saturating).
  - popcount(wr_sel)>=2: no register is written, wr_count unchanged, wr_err <= 1.
- Register 0:
  - wr_sel==32'h1 is an accepted write and increments wr_count, but register 0 stays 0.
  - Reads of address 0 always return 0, bypass included.
- Reads:
  - Combinational from rd_addr_x to rd_data_x.
  - A written value becomes visible to a non-bypassed read in the cycle after the write edge (latency 1).
- Bypass (BYPASS=1): if wr_sel is a legal one-hot for k!=0 and rd_addr_x==k, rd_data_x = wr_data in the same cycle. There is no bypass for illegal selects or register 0.
- Read conflicts: both ports may read the same address simultaneously, with identical results.
- wr_err:
  - Sticky until reset.
  - Set on the first edge after a multi-hot wr_sel is observed; visible the following cycle.
- wr_count: holds at 16'hFFFF after saturation; further legal writes still update registers.

Decomposition:
- Shared package regfile_pkg: NUM_REGS=32, ADDR_W=5, DATA_W default, ZERO_REG=0, COUNT_W=16.
- One sub-module reg32_en: DATA_W flip-flop word with enable and async active-low clear. Instantiated 31 times (registers 1..31).
- Popcount/legality check and read muxes stay inline in the top level.

Test Plan:
- Reset: assert rst_n=0 mid-simulation after writing 32'hDEADBEEF to r5 -> rd_data_a (addr 5) = 0 immediately; wr_count=0; wr_err=0.
- Single write: wr_sel=32'h0000_0020, wr_data=32'hCAFE_F00D, edge, then wr_sel=0 -> rd_addr_a=5 returns 32'hCAFE_F00D next cycle; wr_count=1.
- Bypass, BYPASS=1: wr_sel=32'h8000_0000, wr_data=32'h1234_5678, rd_addr_b=31 in the same cycle -> rd_data_b=32'h1234_5678 before the edge. With BYPASS=0 -> old value 0 before the edge, 32'h1234_5678 after.
- Register 0: wr_sel=32'h1, wr_data=32'hFFFF_FFFF -> rd_data_a (addr 0) = 0 both before and after the edge; wr_count increments by 1.
- Multi-hot: wr_sel=32'h0200_0040 (bits 25 and 6), wr_data=32'hAAAA_AAAA -> r6 and r25 unchanged; wr_err=1 after the edge and stays 1 through 10 subsequent legal writes; wr_count unchanged for that cycle.
- Saturation and dual reads: 65,540 legal writes to r12 -> wr_count=16'hFFFF. Then rd_addr_a=rd_addr_b=12 -> both ports equal the last wr_data.
